pipe_reg: RTL and testbench

PIPE_REG -- requirements
Module: pipe_reg

---
 rtl/pipe_reg_pkg.sv | 12 +
 rtl/pipe_reg_stage.sv | 29 ++
 rtl/pipe_reg.sv | 65 ++++++
 tb/tb_pipe_reg.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// Shared defaults and helpers for the pipe_reg register pipeline.
package pipe_reg_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 4;

    // Width of a counter that must represent 0..depth inclusive
    function automatic int unsigned count_width(input int unsigned depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One pipeline stage: WIDTH-bit data word plus valid flag, with hold and flush.
module pipe_stage #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             flush,
    input  logic [WIDTH-1:0] d,
    input  logic             d_valid,
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    // Flush wins over enable; data is zeroed so a flushed word cannot leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (flush) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (en) begin
            q       <= d;
            q_valid <= d_valid;
        end
    end

endmodule

// File: rtl/pipe_reg.sv
// DEPTH-stage enabled register pipeline with flush and a registered occupancy count.
module pipe_reg
    import pipe_reg_pkg::*;
#(
    parameter  int unsigned WIDTH = DEFAULT_WIDTH,
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned CW    = count_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] stage_data  [DEPTH];
    logic             stage_valid [DEPTH];

    // Stage 0 takes the input port, every later stage takes its predecessor
    for (genvar g = 0; g < DEPTH; g++) begin : g_stage
        if (g == 0) begin : g_head
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .flush   (flush),
                .d       (in),
                .d_valid (in_valid),
                .q       (stage_data[g]),
                .q_valid (stage_valid[g])
            );
        end else begin : g_body
            pipe_stage #(.WIDTH(WIDTH)) u_stage (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en),
                .flush   (flush),
                .d       (stage_data[g-1]),
                .d_valid (stage_valid[g-1]),
                .q       (stage_data[g]),
                .q_valid (stage_valid[g])
            );
        end
    end

    assign out       = stage_data[DEPTH-1];
    assign out_valid = stage_valid[DEPTH-1];

    // Incoming valid and outgoing valid are both known before the edge, so count
    // tracks the valid population exactly; a full pipe always retires a word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (flush) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(in_valid) - CW'(out_valid);
        end
    end

endmodule

// File: tb/tb_pipe_reg.sv
// Self-checking bench for pipe_reg: directed tables, corner sequences, random vs queue model.
module tb_pipe_reg;
    import pipe_reg_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned D   = 4;
    localparam int unsigned CW  = count_width(D);
    localparam int unsigned CW1 = count_width(1);

    logic           clk;
    logic           rst_n;
    logic [W-1:0]   din;
    logic           in_valid;
    logic           en;
    logic           flush;
    logic [W-1:0]   out;
    logic           out_valid;
    logic [CW-1:0]  count;

    logic [W-1:0]   in1;
    logic           iv1;
    logic           en1;
    logic           fl1;
    logic [W-1:0]   out1;
    logic           ov1;
    logic [CW1-1:0] cnt1;

    pipe_reg #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .in(din), .in_valid(in_valid), .en(en),
        .flush(flush), .out(out), .out_valid(out_valid), .count(count)
    );

    pipe_reg #(.WIDTH(W), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in(in1), .in_valid(iv1), .en(en1),
        .flush(fl1), .out(out1), .out_valid(ov1), .count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a queue of DEPTH slots, front = newest word, back = output
    typedef struct packed {
        logic         v;
        logic [W-1:0] d;
    } ent_t;
    ent_t mq[$];

    function automatic void model_reset();
        mq.delete();
        for (int i = 0; i < D; i++) mq.push_back('0);
    endfunction

    function automatic void model_edge(input logic e, input logic f, input logic v, input logic [W-1:0] d);
        ent_t n;
        if (f) begin
            model_reset();
        end else if (e) begin
            n.v = v;
            n.d = d;
            mq.push_front(n);
            void'(mq.pop_back());
        end
    endfunction

    function automatic int model_count();
        int c = 0;
        foreach (mq[i]) c += int'(mq[i].v);
        return c;
    endfunction

    task automatic step(input logic e, input logic f, input logic v, input logic [W-1:0] d);
        en = e; flush = f; in_valid = v; din = d;
        @(posedge clk);
        model_edge(e, f, v, d);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_ov"}, 32'(out_valid), 32'(mq[D-1].v));
        if (mq[D-1].v) chk({tag, "_out"}, 32'(out), 32'(mq[D-1].d));
        chk({tag, "_cnt"}, 32'(count), 32'(model_count()));
    endtask

    typedef struct {
        logic         e;
        logic         f;
        logic         v;
        logic [W-1:0] d;
        logic [W-1:0] eout;
        logic         eov;
        int           ecnt;
    } vec_t;
    vec_t tbl[7];

    ent_t sent[$];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 8'h00, 1'b0, 1};
        tbl[1] = '{1'b1, 1'b0, 1'b1, 8'h22, 8'h00, 1'b0, 2};
        tbl[2] = '{1'b1, 1'b0, 1'b1, 8'h33, 8'h00, 1'b0, 3};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h11, 1'b1, 3};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h22, 1'b1, 2};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h33, 1'b1, 1};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 0};

        rst_n = 1'b0; din = '0; in_valid = 1'b0; en = 1'b0; flush = 1'b0;
        in1 = '0; iv1 = 1'b0; en1 = 1'b0; fl1 = 1'b0;
        model_reset();
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        chk("rst_cnt", 32'(count), 32'h0);
        chk("rst1_ov", 32'(ov1), 32'h0);
        chk("rst1_cnt", 32'(cnt1), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // DEPTH=1: one enabled edge moves the word straight to out
        en1 = 1'b1; in1 = 8'h3C; iv1 = 1'b1;
        @(posedge clk); #1;
        chk("d1_out", 32'(out1), 32'h3C);
        chk("d1_ov", 32'(ov1), 32'h1);
        chk("d1_cnt", 32'(cnt1), 32'h1);
        iv1 = 1'b0; in1 = 8'h00;
        @(posedge clk); #1;
        chk("d1_ov_drain", 32'(ov1), 32'h0);
        chk("d1_cnt_drain", 32'(cnt1), 32'h0);
        en1 = 1'b0;

        // Three-word burst then bubbles
        for (int i = 0; i < 7; i++) begin
            step(tbl[i].e, tbl[i].f, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].eov));
            if (tbl[i].eov) chk($sformatf("tbl%0d_out", i), 32'(out), 32'(tbl[i].eout));
            chk($sformatf("tbl%0d_cnt", i), 32'(count), 32'(tbl[i].ecnt));
        end

        // Hold with en=0 does not advance the word
        step(1'b1, 1'b0, 1'b1, 8'hA5);
        chk("hold_load_cnt", 32'(count), 32'h1);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'b1, 8'h77);
            chk($sformatf("hold%0d_ov", i), 32'(out_valid), 32'h0);
            chk($sformatf("hold%0d_cnt", i), 32'(count), 32'h1);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("rel%0d_ov", i), 32'(out_valid), (i == 2) ? 32'h1 : 32'h0);
        end
        chk("rel_out", 32'(out), 32'hA5);
        chk("rel_cnt", 32'(count), 32'h1);

        // Fill then flush with a valid word on the flush edge
        for (int i = 1; i <= 4; i++) step(1'b1, 1'b0, 1'b1, 8'(i));
        chk("full_cnt", 32'(count), 32'h4);
        chk("full_out", 32'(out), 32'h01);
        chk("full_ov", 32'(out_valid), 32'h1);
        step(1'b1, 1'b1, 1'b1, 8'hFF);
        chk("flush_ov", 32'(out_valid), 32'h0);
        chk("flush_out", 32'(out), 32'h0);
        chk("flush_cnt", 32'(count), 32'h0);
        for (int i = 0; i < D + 2; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("postflush%0d_ov", i), 32'(out_valid), 32'h0);
        end

        // Asynchronous reset with two words in flight
        step(1'b1, 1'b0, 1'b1, 8'h5A);
        step(1'b1, 1'b0, 1'b1, 8'h6B);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 8'h00);
        chk("pre_rst_out", 32'(out), 32'h5A);
        chk("pre_rst_cnt", 32'(count), 32'h2);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_out", 32'(out), 32'h0);
        chk("async_ov", 32'(out_valid), 32'h0);
        chk("async_cnt", 32'(count), 32'h0);
        @(posedge clk); #1;
        chk("in_rst_cnt", 32'(count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 8'h00);
            chk($sformatf("postrst%0d_out", i), 32'(out), 32'h0);
            chk($sformatf("postrst%0d_ov", i), 32'(out_valid), 32'h0);
            chk($sformatf("postrst%0d_cnt", i), 32'(count), 32'h0);
        end

        // Alternating valid/bubble stream: order preserved, occupancy bounded
        sent.delete();
        for (int i = 0; i < 20; i++) begin
            logic v;
            ent_t e;
            v = (i % 2) == 0;
            e.v = 1'b1;
            e.d = 8'(8'h40 + i);
            if (v) sent.push_back(e);
            step(1'b1, 1'b0, v, e.d);
            check_model($sformatf("alt%0d", i));
            if (i >= int'(D)) chk($sformatf("alt%0d_le2", i), 32'(count <= CW'(2)), 32'h1);
            if (out_valid) begin
                if (sent.size() == 0) chk($sformatf("alt%0d_extra", i), 32'(out), 32'hDEAD);
                else chk($sformatf("alt%0d_order", i), 32'(out), 32'(sent.pop_front().d));
            end
        end

        // Random traffic against the queue model
        for (int i = 0; i < 300; i++) begin
            logic e, f, v;
            e = ($urandom_range(3) != 0);
            f = ($urandom_range(19) == 0);
            v = $urandom_range(1) == 1;
            step(e, f, v, 8'($urandom));
            check_model($sformatf("rnd%0d", i));
            chk($sformatf("rnd%0d_bound", i), 32'(count <= CW'(D)), 32'h1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
